// File: rtl/hdmi_video_timing_gen.sv
// hdmi_video_timing_gen
//
// Produces the ADV7513 parallel video interface (HS, VS, DE, 24-bit RGB) once
// the I2C configuration stage reports that the transmitter is configured.
// The ready flag comes from another clock domain, so it passes through a
// two-flop synchroniser first. RGB carries an 8-bar colour test pattern.
// Pixel coordinates are exported for a later frame-buffer stage.
//
// Ports:
//   CLK_PIXEL   in   pixel clock, the only clock of the block
//   RST         in   synchronous active-high reset
//   hdmi_ready  in   configuration-done flag, asynchronous to CLK_PIXEL
//   HDMI_HS     out  horizontal sync (active level set by SYNC_POL)
//   HDMI_VS     out  vertical sync (active level set by SYNC_POL)
//   HDMI_DE     out  data enable, high in the active region
//   HDMI_D      out  pixel data {R, G, B}
//   pixel_x     out  column of the pixel on HDMI_D (0 outside active video)
//   pixel_y     out  row of the pixel on HDMI_D (0 outside active video)
//   frame_start out  one-cycle pulse with pixel (0,0)
//
// State table:
//   IDLE | counters and outputs held at reset values, waiting for ready
//   RUN  | raster counters running, outputs follow the counters by one cycle

module hdmi_video_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic        CLK_PIXEL,
    input  logic        RST,
    input  logic        hdmi_ready,
    output logic        HDMI_HS,
    output logic        HDMI_VS,
    output logic        HDMI_DE,
    output logic [23:0] HDMI_D,
    output logic [11:0] pixel_x,
    output logic [11:0] pixel_y,
    output logic        frame_start
);

    // Both totals must fit the 12-bit counters (<= 4095).
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        s1_q, s2_q;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic [11:0] col_q, col_d;
    logic [2:0]  bar_q, bar_d;

    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        de_q, de_d;
    logic [23:0] rgb_q, rgb_d;
    logic [11:0] px_q, px_d;
    logic [11:0] py_q, py_d;
    logic        fs_q, fs_d;

    logic        active_h, active_v, hs_on, vs_on;
    logic [23:0] bar_rgb;

    assign active_h = (h_cnt_q < H_ACT);
    assign active_v = (v_cnt_q < V_ACT);
    assign hs_on    = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    assign vs_on    = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

    always_comb begin
        bar_rgb = 24'h000000;
        case (bar_q)
            3'd0: bar_rgb = 24'hFFFFFF;
            3'd1: bar_rgb = 24'hFFFF00;
            3'd2: bar_rgb = 24'h00FFFF;
            3'd3: bar_rgb = 24'h00FF00;
            3'd4: bar_rgb = 24'hFF00FF;
            3'd5: bar_rgb = 24'hFF0000;
            3'd6: bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        h_cnt_d = 12'd0;
        v_cnt_d = 12'd0;
        col_d   = 12'd0;
        bar_d   = 3'd0;
        hs_d    = ~SYNC_POL;
        vs_d    = ~SYNC_POL;
        de_d    = 1'b0;
        rgb_d   = 24'h000000;
        px_d    = 12'd0;
        py_d    = 12'd0;
        fs_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!s2_q) begin
                    // Abort immediately; defaults restore the idle values.
                    state_d = IDLE;
                end else begin
                    if (h_cnt_q == H_LAST) begin
                        h_cnt_d = 12'd0;
                        v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
                    end else begin
                        h_cnt_d = h_cnt_q + 12'd1;
                        v_cnt_d = v_cnt_q;
                    end

                    // Bar index tracks h_cnt / (H_ACTIVE/8) without a divider.
                    // Past the active region it keeps counting, but DE masks it.
                    if (h_cnt_q == H_LAST) begin
                        col_d = 12'd0;
                        bar_d = 3'd0;
                    end else if (col_q == BAR_LAST) begin
                        col_d = 12'd0;
                        bar_d = bar_q + 3'd1;
                    end else begin
                        col_d = col_q + 12'd1;
                        bar_d = bar_q;
                    end

                    de_d  = active_h & active_v;
                    hs_d  = hs_on ? SYNC_POL : ~SYNC_POL;
                    vs_d  = vs_on ? SYNC_POL : ~SYNC_POL;
                    rgb_d = (active_h & active_v) ? bar_rgb : 24'h000000;
                    px_d  = (active_h & active_v) ? h_cnt_q : 12'd0;
                    py_d  = (active_h & active_v) ? v_cnt_q : 12'd0;
                    fs_d  = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_PIXEL) begin
        if (RST) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= IDLE;
            h_cnt_q <= 12'd0;
            v_cnt_q <= 12'd0;
            col_q   <= 12'd0;
            bar_q   <= 3'd0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
            de_q    <= 1'b0;
            rgb_q   <= 24'h000000;
            px_q    <= 12'd0;
            py_q    <= 12'd0;
            fs_q    <= 1'b0;
        end else begin
            s1_q    <= hdmi_ready;
            s2_q    <= s1_q;
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            col_q   <= col_d;
            bar_q   <= bar_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            rgb_q   <= rgb_d;
            px_q    <= px_d;
            py_q    <= py_d;
            fs_q    <= fs_d;
        end
    end

    assign HDMI_HS     = hs_q;
    assign HDMI_VS     = vs_q;
    assign HDMI_DE     = de_q;
    assign HDMI_D      = rgb_q;
    assign pixel_x     = px_q;
    assign pixel_y     = py_q;
    assign frame_start = fs_q;

endmodule
